// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit -- MIPS fetch stage.
//
// Generates sequential PCs, issues them to instruction memory over a req/gnt
// channel with in-order rvalid responses, parks returned words with their PCs
// in a small in-order reservation FIFO, and offers the head to the IR through
// a valid/ready handshake. A redirect flushes the FIFO and restarts at a new
// PC. Responses still in flight at that point are counted in drop_cnt and
// discarded when they arrive.
//
// Optional feature macro: IFU_ALIGN_CHECK_EN
//   defined   : misaligned redirect target raises a sticky fetch_fault and
//               stalls fetch until an aligned redirect arrives.
//   undefined : fetch_fault tied to 0, redirect_pc[1:0] ignored.
//
// Ports
//   clk, reset            clock, async active-low reset
//   redirect, redirect_pc flush and restart request
//   imem_req/addr/gnt     fetch request channel
//   imem_rvalid/rdata     in-order response channel
//   out_valid/instr/pc    head instruction offered to the IR
//   out_ready             IR accepts the head this cycle
//   fetch_fault           misaligned-redirect flag
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;           // counts reach FIFO_DEPTH
  localparam int OW = CW + 1;           // occupancy sum headroom
  localparam logic [PW-1:0] PONE    = 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  logic [31:0]                 fetch_pc;
  logic [FIFO_DEPTH-1:0][31:0] slot_pc;
  logic [FIFO_DEPTH-1:0][31:0] slot_instr;
  logic [PW-1:0]               head, tail;
  // Slots are filled strictly in order, so the filled slots are always the
  // first nfill entries from head; this replaces per-slot filled flags.
  logic [CW-1:0]               used, nfill, drop_cnt;

  logic          pop, fire, fill, drop_dec;
  logic [CW-1:0] unfilled, pending, redir_drop;
  logic [PW-1:0] fill_ptr;
  logic [OW-1:0] occ;
  logic [31:0]   redir_pc;

  assign out_valid = (nfill != '0);
  assign out_pc    = slot_pc[head];
  assign out_instr = slot_instr[head];

  assign pop      = out_valid & out_ready & ~redirect;
  assign unfilled = used - nfill;
  assign fill_ptr = head + nfill[PW-1:0];
  assign fill     = imem_rvalid & (drop_cnt == '0) & (unfilled != '0);
  assign drop_dec = imem_rvalid & (drop_cnt != '0);

  // Slots held plus responses still owed to the memory; a same-cycle pop
  // frees its slot for this cycle's request.
  assign occ = {1'b0, used} + {1'b0, drop_cnt} - OW'(pop);

  // Gated by reset so no request is raised while held in reset.
  assign imem_req  = reset & ~redirect & ~fetch_fault & (occ < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign fire      = imem_req & imem_gnt;

  // Everything reserved but not yet filled becomes garbage in flight. A
  // response arriving during the redirect is one of those and is consumed now.
  assign pending    = drop_cnt + unfilled;
  assign redir_drop = pending - CW'(imem_rvalid && (pending != '0));
  assign redir_pc   = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      slot_pc    <= '0;
      slot_instr <= '0;
      head       <= '0;
      tail       <= '0;
      used       <= '0;
      nfill      <= '0;
      drop_cnt   <= '0;
    end else if (redirect) begin
      fetch_pc <= redir_pc;
      head     <= '0;
      tail     <= '0;
      used     <= '0;
      nfill    <= '0;
      drop_cnt <= redir_drop;
    end else begin
      if (fire) begin
        slot_pc[tail] <= fetch_pc;
        tail          <= tail + PONE;
        fetch_pc      <= fetch_pc + 32'd4;
      end
      if (fill)     slot_instr[fill_ptr] <= imem_rdata;
      if (pop)      head <= head + PONE;
      if (drop_dec) drop_cnt <= drop_cnt - CW'(1);
      used  <= used + CW'(fire) - CW'(pop);
      nfill <= nfill + CW'(fill) - CW'(pop);
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        fault_q <= 1'b0;
    else if (redirect) fault_q <= |redirect_pc[1:0];
  end
  assign fetch_fault = fault_q;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model of the fetch
// buffer plus an in-order memory model returning addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk, reset, redirect, imem_gnt, imem_rvalid, out_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, out_valid, fetch_fault;
  logic [31:0] imem_addr, out_instr, out_pc;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;

  // reference model
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_fault;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          q_fill[$];
  logic [31:0] mem_q[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_ins[$];

  // knobs (percent) and one-shot redirect
  int          k_gnt, k_rdy, k_rv, k_rd;
  bit          force_rd;
  logic [31:0] force_rpc;

  // values sampled in the last step
  bit          s_req, s_valid, s_fault, s_gnt;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = ($urandom_range(4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
    if ($urandom_range(7) == 0) v[1:0] = 2'($urandom_range(3));
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_drop = 0; m_fault = 0;
    q_pc.delete(); q_ins.delete(); q_fill.delete(); mem_q.delete();
  endtask

  // One cycle: entered at posedge+1, drives, checks at negedge, updates the
  // model, returns at the next posedge+1.
  task automatic step();
    bit ev, pop, ereq;
    int unf, pend, idx;
    redirect    = force_rd ? 1'b1 : pct(k_rd);
    redirect_pc = force_rd ? force_rpc : rand_pc();
    force_rd    = 1'b0;
    imem_gnt    = pct(k_gnt);
    imem_rvalid = (mem_q.size() > 0) && pct(k_rv);
    imem_rdata  = imem_rvalid ? (mem_q[0] ^ XORK) : $urandom;
    out_ready   = pct(k_rdy);
    @(negedge clk);
    ev   = (q_pc.size() > 0) && q_fill[0];
    pop  = ev && out_ready && !redirect;
    ereq = !redirect && !m_fault && ((q_pc.size() - int'(pop) + m_drop) < DEPTH);
    s_req = imem_req; s_valid = out_valid; s_fault = fetch_fault; s_gnt = imem_gnt;
    s_addr = imem_addr; s_pc = out_pc; s_instr = out_instr;
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (ev) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instr", out_instr, q_ins[0]);
    end
    // memory and consumer side
    if (out_valid && out_ready && !redirect) begin
      popped_pc.push_back(out_pc); popped_ins.push_back(out_instr);
    end
    if (imem_rvalid) void'(mem_q.pop_front());
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
    // model update
    if (redirect) begin
      unf = 0;
      foreach (q_fill[i]) if (!q_fill[i]) unf++;
      pend   = m_drop + unf;
      m_drop = (imem_rvalid && pend > 0) ? pend - 1 : pend;
      q_pc.delete(); q_ins.delete(); q_fill.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFU_ALIGN_CHECK_EN
      m_fault = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          idx = -1;
          foreach (q_fill[i]) if (idx < 0 && !q_fill[i]) idx = i;
          if (idx >= 0) begin q_ins[idx] = imem_rdata; q_fill[idx] = 1'b1; end
        end
      end
      if (pop) begin
        void'(q_pc.pop_front()); void'(q_ins.pop_front()); void'(q_fill.pop_front());
      end
      if (ereq && imem_gnt) begin
        q_pc.push_back(m_pc); q_ins.push_back(32'h0); q_fill.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Entered at posedge+1; asserts reset asynchronously, checks reset values,
  // releases at a later posedge+1.
  task automatic do_reset();
    redirect = 0; imem_gnt = 0; imem_rvalid = 0; out_ready = 0; force_rd = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic knobs(int g, int r, int v, int d);
    k_gnt = g; k_rdy = r; k_rv = v; k_rd = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    reset = 0; redirect = 0; redirect_pc = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = 0; out_ready = 0; force_rd = 0; force_rpc = 0;
    knobs(0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // streaming from reset, 1-cycle memory, always ready
    knobs(100, 100, 100, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        chk("t1_first_req", 32'(s_req), 32'h1);
        chk("t1_first_addr", s_addr, 32'h0);
      end
      chk("t1_valid", 32'(s_valid), 32'(i >= 2));
      if (i >= 2) begin
        chk("t1_pc", s_pc, 32'((i - 2) * 4));
        chk("t1_instr", s_instr, 32'((i - 2) * 4) ^ XORK);
      end
    end

    // consumer stalled for 5 cycles
    do_reset();
    knobs(100, 0, 100, 0);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_req && s_gnt) grants++;
      if (i >= 2) begin
        chk("t2_hold_valid", 32'(s_valid), 32'h1);
        chk("t2_hold_pc", s_pc, 32'h0);
      end
    end
    chk("t2_grants", 32'(grants), 32'd2);
    popped_pc.delete(); popped_ins.delete();
    k_rdy = 100;
    repeat (6) step();
    chk("t2_popcnt_ge3", 32'(popped_pc.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < popped_pc.size(); i++)
      chk("t2_order", popped_pc[i], 32'(i * 4));

    // grant withheld for 3 cycles
    do_reset();
    knobs(0, 100, 100, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_held", 32'(s_req), 32'h1);
      chk("t3_addr_held", s_addr, 32'h0);
    end
    k_gnt = 100; k_rv = 0;
    step();
    chk("t3_used_one", 32'(dut.used), 32'h1);
    step();
    chk("t3_next_addr", s_addr, 32'h4);

    // redirect with two requests in flight
    do_reset();
    knobs(100, 100, 0, 0);
    repeat (3) step();
    force_rd = 1; force_rpc = 32'h100;
    step();
    chk("t4_drop_two", 32'(dut.drop_cnt), 32'd2);
    popped_pc.delete(); popped_ins.delete();
    k_rv = 100;
    repeat (8) step();
    chk("t4_popcnt", 32'(popped_pc.size() > 0), 32'h1);
    if (popped_pc.size() > 0) begin
      chk("t4_first_pc", popped_pc[0], 32'h100);
      chk("t4_first_instr", popped_ins[0], 32'h100 ^ XORK);
    end
    chk("t4_drop_zero", 32'(dut.drop_cnt), 32'h0);

    // redirect coinciding with a response
    do_reset();
    knobs(100, 100, 0, 0);
    step();
    force_rd = 1; force_rpc = 32'h40; k_rv = 100;
    popped_pc.delete(); popped_ins.delete();
    step();
    repeat (6) step();
    chk("t5_popcnt", 32'(popped_pc.size() > 0), 32'h1);
    if (popped_pc.size() > 0) chk("t5_first_pc", popped_pc[0], 32'h40);

    // misaligned redirect target
    do_reset();
    knobs(100, 100, 100, 0);
    force_rd = 1; force_rpc = 32'h102;
    step();
    step();
`ifdef IFU_ALIGN_CHECK_EN
    chk("t6_fault_set", 32'(s_fault), 32'h1);
    chk("t6_req_off", 32'(s_req), 32'h0);
    step();
    chk("t6_fault_sticky", 32'(s_fault), 32'h1);
    force_rd = 1; force_rpc = 32'h200;
    step();
    step();
    chk("t6_fault_clr", 32'(s_fault), 32'h0);
    chk("t6_req_on", 32'(s_req), 32'h1);
    chk("t6_addr", s_addr, 32'h200);
`else
    chk("t6_no_fault", 32'(s_fault), 32'h0);
    chk("t6_req_on", 32'(s_req), 32'h1);
    chk("t6_addr_forced", s_addr, 32'h100);
`endif

    // randomized traffic, with a reset in the middle
    knobs(70, 70, 60, 4);
    repeat (1500) step();
    do_reset();
    repeat (1500) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the MIPS pipeline. Generates the sequential PC, issues requests to instruction memory over a req/gnt + rvalid interface, buffers returned words with their PCs in a small in-order reservation FIFO, and presents them to the instruction register through a valid/ready handshake. The instruction register's `load` is driven by `out_valid & out_ready`. A branch/jump redirect flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 2: reservation slots; power of two, at least 2.

- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `redirect`  input  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  input  32  new fetch address.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  32  fetch address; word aligned.
- `imem_gnt`  input  1  request accepted this cycle.
- `imem_rvalid`  input  1  response word valid; responses return in request order.
- `imem_rdata`  input  32  response instruction.
- `out_valid`  output  1  head slot holds a filled instruction.
- `out_instr`  output  32  head instruction.
- `out_pc`  output  32  PC of head instruction.
- `out_ready`  input  1  consumer (IR) accepts head this cycle.
- `fetch_fault`  output  1  misaligned redirect flag; see Configuration.

## Operation
- State: `fetch_pc`, FIFO of {pc, instr, filled} slots with head/tail pointers, `used` count, `drop_cnt`.
- Pop: `out_valid & out_ready` frees the head slot.
- Credit: `used - pop + drop_cnt < FIFO_DEPTH`. Same-cycle pop counts, so there is a combinational path from `out_ready` to `imem_req`. There is no path from `imem_gnt` to the `out_*` signals.
- Issue:
  - `imem_req = credit & !redirect` (and no fault; see Configuration). `imem_addr = fetch_pc`.
  - On `imem_req & imem_gnt`: reserve the tail slot with pc=`fetch_pc`, filled=0, then `fetch_pc += 4` (wraps mod 2^32).
- Fill: on `imem_rvalid`:
  - If `drop_cnt > 0`: discard the word and decrement `drop_cnt`.
  - Otherwise: write `imem_rdata` into the oldest unfilled slot and set filled=1.
  - `imem_rvalid` with nothing pending is ignored.
- Redirect (single cycle, takes priority over issue, fill and pop):
  - All slots invalidated; `used <= 0`; `fetch_pc <= redirect_pc`; no pop occurs.
  - `drop_cnt <= drop_cnt + unfilled_reserved - imem_rvalid`. A response arriving in the redirect cycle is discarded.
  - `out_valid` is 0 from the next cycle until fresh data fills.
- Back-to-back redirects: each recomputes `drop_cnt` the same way; the last one wins.

## Timing
- Reset (asynchronous assert, `reset`=0):
  - `fetch_pc = RESET_PC`.
  - `used`, `drop_cnt`, pointers = 0.
  - `out_valid`, `imem_req`, `fetch_fault` = 0.
  - `out_instr`, `out_pc` = 0.
- First cycle after deassert: `imem_req=1`, `imem_addr=RESET_PC`.
- Latency: `imem_rvalid` in cycle N makes `out_valid`=1 in cycle N+1 (registered fill, no bypass).
- With a 1-cycle memory and `out_ready` held at 1, steady-state throughput is 1 instruction per cycle.
- While `imem_req & !imem_gnt`, `imem_addr` is held stable. A request is retracted only by a redirect.
- Reset mid-operation: all state cleared immediately; any later responses from the old request are the memory's responsibility to squash.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_fault` from the next cycle. It is sticky.
  - While `fetch_fault` is set, `imem_req` is held at 0.
  - A later redirect with an aligned target clears `fetch_fault` and resumes fetch.
- Not defined:
  - `fetch_fault` is tied to 0.
  - `redirect_pc[1:0]` is ignored; bits are forced to 00.

## Test plan
- Reset release, 1-cycle memory returning `addr ^ 32'hA5A5_0000`, `out_ready`=1 → `out_pc` 0,4,8,… on consecutive cycles with matching `out_instr`; `out_valid` first high 2 cycles after the first grant.
- `out_ready`=0 for 5 cycles → `imem_req` drops after 2 grants; `out_pc`/`out_instr` stay at pc 0. On release, pcs 0,4,8 emerge in order with none lost.
- `imem_gnt` low for 3 cycles → `imem_addr` is held at the same value the whole time; one slot is reserved when the grant is given.
- Redirect to 0x100 with 2 requests in flight → both late responses are discarded; next `out_pc`=0x100; `drop_cnt` returns to 0.
- Redirect in the same cycle as `imem_rvalid` → that word never appears at the output.
- `IFU_ALIGN_CHECK_EN`: redirect to 0x102 → `fetch_fault`=1 and `imem_req`=0. Redirect to 0x200 → fault clears and fetch resumes at 0x200.
